// File: rtl/serial_parity_checker_pkg.sv
// Shared encodings for the serial parity link: FSM states and line-level bit values.
package serial_parity_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit counter wide enough to hold DATA_W without wrapping inside a frame.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bit-serial input and word-level result bundle of the parity checker.
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_bit;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output in_valid, in_bit,
        input  out_valid, out_data, parity_err, frame_err, busy
    );

    modport slave (
        input  in_valid, in_bit,
        output out_valid, out_data, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_parity_checker_xor2_nand.sv
// Two-input XOR from four NAND2 gates; shared with the transmit-side parity generator.
module xor2_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    logic n_ab;
    logic n_a;
    logic n_b;

    assign n_ab = ~(a & b);
    assign n_a  = ~(a & n_ab);
    assign n_b  = ~(b & n_ab);
    assign y    = ~(n_a & n_b);
endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: start, DATA_W bits LSB first, parity, stop.
// Rebuilds the word, checks parity with a running XOR and flags a missing stop bit.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  link
);
    localparam int CNT_W = cnt_width(DATA_W);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_q, acc_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                perr_q, perr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                parity_err_q, parity_err_d;
    logic                frame_err_q, frame_err_d;
    logic                acc_x;
    logic                last_data;

    xor2_nand u_acc_xor (
        .a (acc_q),
        .b (link.in_bit),
        .y (acc_x)
    );

    assign last_data = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (link.in_valid) begin
            unique case (state_q)
                ST_IDLE:   if (link.in_bit == START_BIT) state_d = ST_DATA;
                ST_DATA:   if (last_data) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shreg_d      = shreg_q;
        perr_d       = perr_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (link.in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (link.in_bit == START_BIT) begin
                        cnt_d = '0;
                        acc_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg_d = {link.in_bit, shreg_q[DATA_W-1:1]};
                    acc_d   = acc_x;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                ST_PARITY: perr_d = acc_x ^ PARITY_ODD;
                ST_STOP: begin
                    out_valid_d  = 1'b1;
                    out_data_d   = shreg_q;
                    parity_err_d = perr_q;
                    frame_err_d  = (link.in_bit != STOP_BIT);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shreg_q      <= shreg_d;
            perr_q       <= perr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign link.out_valid  = out_valid_q;
    assign link.out_data   = out_data_q;
    assign link.parity_err = parity_err_q;
    assign link.frame_err  = frame_err_q;
    assign link.busy       = (state_q != ST_IDLE);
endmodule
